// File: rtl/bus_timer_pkg.sv
// Shared register map constants for the memory-mapped down-counter timer.
// Offsets select the word inside the 4-word window; bit positions index CTRL/STATUS.
package bus_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_AR        = 1;
  localparam int CTRL_IE        = 2;
  localparam int CTRL_PRESC_LSB = 8;

  localparam int ST_EXP = 0;
  localparam int ST_RUN = 1;

  function automatic logic [15:0] pack_ctrl(input logic en, input logic ar,
                                            input logic ie, input logic [7:0] presc);
    logic [15:0] w;
    w = '0;
    w[CTRL_EN] = en;
    w[CTRL_AR] = ar;
    w[CTRL_IE] = ie;
    w[CTRL_PRESC_LSB +: 8] = presc;
    return w;
  endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Divides the clock by (presc+1) while enabled, producing a one-cycle tick.
// Held at zero while disabled or when the CPU rewrites CTRL.
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] presc,
  output logic       tick
);

  logic [7:0] r_cnt;
  logic       w_hit;

  assign w_hit = (r_cnt == presc);
  assign tick  = en & w_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr || !en || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Bus-attached programmable down-counter: 4-word register window, combinational
// reads, sticky expiry flag and level interrupt request.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter logic [15:0] RESET_RELOAD = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        data_write_en,
  output logic [15:0] data_out,
  output logic        sel,
  output logic        irq
);

  logic        r_en;
  logic        r_ar;
  logic        r_ie;
  logic [7:0]  r_presc;
  logic [15:0] r_reload;
  logic [15:0] r_count;
  logic        r_expired;

  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_reload;
  logic        w_wr_count;
  logic        w_wr_status;
  logic        w_tick;
  logic        w_terminal;
  logic [15:0] w_status;

  assign sel         = (addr[15:2] == BASE_ADDR[15:2]);
  assign w_wr        = sel & data_write_en;
  assign w_wr_ctrl   = w_wr & (addr[1:0] == REG_CTRL);
  assign w_wr_reload = w_wr & (addr[1:0] == REG_RELOAD);
  assign w_wr_count  = w_wr & (addr[1:0] == REG_COUNT);
  assign w_wr_status = w_wr & (addr[1:0] == REG_STATUS);

  // Expiry is judged on the COUNT value before any same-cycle CPU write.
  assign w_terminal = w_tick & (r_count == 16'd0);

  timer_prescaler u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (r_en),
    .clr   (w_wr_ctrl),
    .presc (r_presc),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en    <= 1'b0;
      r_ar    <= 1'b0;
      r_ie    <= 1'b0;
      r_presc <= '0;
    end else if (w_wr_ctrl) begin
      r_en    <= data_in[CTRL_EN];
      r_ar    <= data_in[CTRL_AR];
      r_ie    <= data_in[CTRL_IE];
      r_presc <= data_in[CTRL_PRESC_LSB +: 8];
    end else if (w_terminal && !r_ar) begin
      r_en <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reload <= RESET_RELOAD;
    end else if (w_wr_reload) begin
      r_reload <= data_in;
    end
  end

  // A CPU write to COUNT overrides whatever the tick would have done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= RESET_RELOAD;
    end else if (w_wr_count) begin
      r_count <= data_in;
    end else if (w_tick) begin
      if (!w_terminal) begin
        r_count <= r_count - 16'd1;
      end else if (r_ar) begin
        r_count <= r_reload;
      end else begin
        r_count <= 16'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_expired <= 1'b0;
    end else if (w_terminal) begin
      r_expired <= 1'b1;
    end else if (w_wr_status && data_in[ST_EXP]) begin
      r_expired <= 1'b0;
    end
  end

  always_comb begin
    w_status         = '0;
    w_status[ST_EXP] = r_expired;
    w_status[ST_RUN] = r_en;
  end

  always_comb begin
    data_out = 16'h0000;
    if (sel) begin
      case (addr[1:0])
        REG_CTRL:   data_out = pack_ctrl(r_en, r_ar, r_ie, r_presc);
        REG_RELOAD: data_out = r_reload;
        REG_COUNT:  data_out = r_count;
        default:    data_out = w_status;
      endcase
    end
  end

  assign irq = r_expired & r_ie;

endmodule
